sfft_bitstream_decoder: RTL and testbench
=========================================

SFFT_BITSTREAM_DECODER -- requirements
Module: sfft_bitstream_decoder

Interface
REQ-001 SHALL have parameter BITWIDTH, default 8: decode window is 2^BITWIDTH enabled samples.
REQ-002 SHALL have parameter NUMINPUTS, default 2: number of real/imaginary bitstream lane pairs.
REQ-003 SHALL have parameter CW, default BITWIDTH+1: per-lane count width, not overridden.
REQ-004 SHALL have port iClk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port iRstN, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port iEn, input, 1 bit: sample-enable; a cycle with iEn=0 neither counts nor advances the window.
REQ-007 SHALL have port iClr, input, 1 bit: synchronous clear.
REQ-008 SHALL have port iStart, input, 1 bit: begins a decode window; honoured only in IDLE.
REQ-009 SHALL have port iReal, input, NUMINPUTS bits: real-part bitstreams from the SFFT output, one bit per lane.
REQ-010 SHALL have port iImg, input, NUMINPUTS bits: imaginary-part bitstreams, one bit per lane.
REQ-011 SHALL have port iReady, input, 1 bit: downstream accepts the result.
REQ-012 SHALL have port oValid, output, 1 bit: result registers hold a completed window.
REQ-013 SHALL have port oBusy, output, 1 bit: high in ACCUM.
REQ-014 SHALL have port oReal, output, NUMINPUTS*CW bits: ones-count per real lane, lane k at bits [k*CW +: CW].
REQ-015 SHALL have port oImg, output, NUMINPUTS*CW bits: ones-count per imaginary lane, same packing.

Function
REQ-016 SHALL implement FSM states IDLE, ACCUM, HOLD.
REQ-017 SHALL move IDLE->ACCUM on iStart=1, zeroing sample counter and all 2*NUMINPUTS lane accumulators; the iStart cycle itself takes no sample.
REQ-018 SHALL, in ACCUM on each cycle with iEn=1, add each lane's input bit to its CW-bit accumulator and increment a BITWIDTH-bit sample counter.
REQ-019 SHALL treat the enabled sample taken while the sample counter equals 2^BITWIDTH-1 as the last; that same edge loads accumulator+bit into oReal/oImg, sets oValid=1, enters HOLD.
REQ-020 SHALL give latency: oValid high the cycle after the 2^BITWIDTH-th enabled sample edge.
REQ-021 SHALL never overflow a count: range 0..2^BITWIDTH inclusive fits CW bits.
REQ-022 SHALL keep oValid, oReal, oImg stable throughout HOLD until the handshake.
REQ-023 SHALL complete the handshake on an edge with oValid=1 and iReady=1: oValid=0 next cycle, state IDLE, oReal/oImg retain last values.
REQ-024 SHALL ignore iReady when oValid=0, iStart outside IDLE, and iEn outside ACCUM.
REQ-025 SHALL, on iClr=1 in any state, go to IDLE, zero counter, accumulators, oReal, oImg, and drive oValid=0; iClr overrides simultaneous iStart, last sample, or handshake.
REQ-026 SHALL drive oBusy=1 exactly in ACCUM.

Reset
REQ-027 SHALL, while iRstN=0, immediately force IDLE, oValid=0, oBusy=0, oReal=0, oImg=0, counter and accumulators 0, regardless of clock.
REQ-028 SHALL, after iRstN rises, stay in IDLE until an iStart; a reset mid-window discards partial counts.

Verification (BITWIDTH=4, NUMINPUTS=2)
REQ-029 SHALL cover: assert iRstN=0 mid-clock -> all outputs 0 immediately, oBusy=0.
REQ-030 SHALL cover: iStart, then 16 cycles iEn=1 with iReal=2'b01 constant, iImg lane0=1010..., lane1=0101... -> oValid=1 one cycle after 16th sample, oReal={5'd0,5'd16}, oImg={5'd8,5'd8}.
REQ-031 SHALL cover: same stimulus with iEn toggling 1,0,1,0 and lanes changed on disabled cycles -> identical counts, oValid after 32 cycles.
REQ-032 SHALL cover: iReady low 5 cycles in HOLD with iStart pulsed -> oValid and data unchanged, no new window; iReady=1 -> oValid=0 next cycle, IDLE.
REQ-033 SHALL cover: iClr at 7th enabled sample -> IDLE, oBusy=0, no oValid; subsequent window with all-zero inputs -> counts all 0.
REQ-034 SHALL cover: iClr and iReady high on same edge in HOLD -> oValid=0, oReal=oImg=0.

Source files
------------

// File: rtl/sfft_bitstream_decoder_if.sv
// Bundle of the decoder's control, bitstream and result signals.
interface sfft_bitstream_decoder_if #(
  parameter int unsigned NUMINPUTS = 2,
  parameter int unsigned CW        = 9
);
  logic                    iEn;
  logic                    iClr;
  logic                    iStart;
  logic [NUMINPUTS-1:0]    iReal;
  logic [NUMINPUTS-1:0]    iImg;
  logic                    iReady;
  logic                    oValid;
  logic                    oBusy;
  logic [NUMINPUTS*CW-1:0] oReal;
  logic [NUMINPUTS*CW-1:0] oImg;

  // Stimulus side: drives controls and bitstreams, consumes results.
  modport master (
    output iEn, iClr, iStart, iReal, iImg, iReady,
    input  oValid, oBusy, oReal, oImg
  );

  // Decoder side.
  modport slave (
    input  iEn, iClr, iStart, iReal, iImg, iReady,
    output oValid, oBusy, oReal, oImg
  );
endinterface

// File: rtl/sfft_bitstream_decoder.sv
// Counts ones on each real/imaginary SFFT bitstream lane over a window of
// 2^BITWIDTH enabled samples and presents the counts with a valid/ready
// handshake.
module sfft_bitstream_decoder #(
  parameter int unsigned BITWIDTH  = 8,
  parameter int unsigned NUMINPUTS = 2,
  parameter int unsigned CW        = BITWIDTH + 1
) (
  input  logic                    iClk,
  input  logic                    iRstN,
  input  logic                    iEn,
  input  logic                    iClr,
  input  logic                    iStart,
  input  logic [NUMINPUTS-1:0]    iReal,
  input  logic [NUMINPUTS-1:0]    iImg,
  input  logic                    iReady,
  output logic                    oValid,
  output logic                    oBusy,
  output logic [NUMINPUTS*CW-1:0] oReal,
  output logic [NUMINPUTS*CW-1:0] oImg
);

  localparam logic [BITWIDTH-1:0] CNT_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [BITWIDTH-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]           acc_re_q [NUMINPUTS];
  logic [CW-1:0]           acc_re_d [NUMINPUTS];
  logic [CW-1:0]           acc_im_q [NUMINPUTS];
  logic [CW-1:0]           acc_im_d [NUMINPUTS];
  logic [NUMINPUTS*CW-1:0] out_re_q, out_re_d;
  logic [NUMINPUTS*CW-1:0] out_im_q, out_im_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;

  // Next-state: clear dominates; last enabled sample loads results directly.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    out_re_d = out_re_q;
    out_im_d = out_im_q;
    valid_d  = valid_q;
    busy_d   = busy_q;

    if (iClr) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      acc_re_d = '{default: '0};
      acc_im_d = '{default: '0};
      out_re_d = '0;
      out_im_d = '0;
      valid_d  = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (iStart) begin
            state_d  = S_ACCUM;
            cnt_d    = '0;
            acc_re_d = '{default: '0};
            acc_im_d = '{default: '0};
            busy_d   = 1'b1;
          end
        end
        S_ACCUM: begin
          if (iEn) begin
            for (int k = 0; k < NUMINPUTS; k++) begin
              acc_re_d[k] = acc_re_q[k] + CW'(iReal[k]);
              acc_im_d[k] = acc_im_q[k] + CW'(iImg[k]);
            end
            cnt_d = cnt_q + BITWIDTH'(1);
            if (cnt_q == CNT_LAST) begin
              for (int k = 0; k < NUMINPUTS; k++) begin
                out_re_d[k*CW +: CW] = acc_re_d[k];
                out_im_d[k*CW +: CW] = acc_im_d[k];
              end
              valid_d = 1'b1;
              busy_d  = 1'b0;
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (iReady) begin
            valid_d = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and result registers with asynchronous active-low reset.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_re_q <= '{default: '0};
      acc_im_q <= '{default: '0};
      out_re_q <= '0;
      out_im_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
      out_re_q <= out_re_d;
      out_im_q <= out_im_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign oValid = valid_q;
  assign oBusy  = busy_q;
  assign oReal  = out_re_q;
  assign oImg   = out_im_q;

endmodule

// File: tb/tb_sfft_bitstream_decoder.sv
// Self-checking bench for sfft_bitstream_decoder (BITWIDTH=4, NUMINPUTS=2).
module tb_sfft_bitstream_decoder;

  localparam int unsigned BW  = 4;
  localparam int unsigned NI  = 2;
  localparam int unsigned CW  = BW + 1;
  localparam int          WIN = 1 << BW;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [NI*CW-1:0] exp_re_v;
  logic [NI*CW-1:0] exp_im_v;

  sfft_bitstream_decoder_if #(.NUMINPUTS(NI), .CW(CW)) bus ();

  sfft_bitstream_decoder #(.BITWIDTH(BW), .NUMINPUTS(NI)) dut (
    .iClk   (clk),
    .iRstN  (rst_n),
    .iEn    (bus.iEn),
    .iClr   (bus.iClr),
    .iStart (bus.iStart),
    .iReal  (bus.iReal),
    .iImg   (bus.iImg),
    .iReady (bus.iReady),
    .oValid (bus.oValid),
    .oBusy  (bus.oBusy),
    .oReal  (bus.oReal),
    .oImg   (bus.oImg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic v, input logic b,
                             input logic [NI*CW-1:0] re, input logic [NI*CW-1:0] im);
    chk({tag, "_valid"}, 64'(bus.oValid), 64'(v));
    chk({tag, "_busy"},  64'(bus.oBusy),  64'(b));
    chk({tag, "_real"},  64'(bus.oReal),  64'(re));
    chk({tag, "_img"},   64'(bus.oImg),   64'(im));
  endtask

  // One full window. mode 0: spec pattern, 1: all-zero, 2: random lanes.
  // Enable pattern: 0 always, 1 alternating 1/0, 2 random.
  // Lanes and iStart/iReady are randomized on cycles that must be ignored.
  task automatic run_window(input string tag, input int mode, input int en_mode);
    int re_cnt [NI];
    int im_cnt [NI];
    int taken;
    int cyc;
    logic en;
    logic [NI-1:0] r;
    logic [NI-1:0] m;
    for (int k = 0; k < NI; k++) begin
      re_cnt[k] = 0;
      im_cnt[k] = 0;
    end
    taken = 0;
    cyc   = 0;
    bus.iStart = 1'b1;
    bus.iEn    = 1'($urandom);
    bus.iReal  = NI'($urandom);
    bus.iImg   = NI'($urandom);
    tick();
    bus.iStart = 1'b0;
    chk({tag, "_start_busy"},  64'(bus.oBusy),  64'd1);
    chk({tag, "_start_valid"}, 64'(bus.oValid), 64'd0);
    while (taken < WIN && cyc < 400) begin
      case (en_mode)
        0:       en = 1'b1;
        1:       en = (cyc % 2 == 0);
        default: en = ($urandom_range(0, 3) != 0);
      endcase
      r = NI'($urandom);
      m = NI'($urandom);
      if (en) begin
        if (mode == 0) begin
          r = 2'b01;
          m = {1'(taken % 2 == 1), 1'(taken % 2 == 0)};
        end else if (mode == 1) begin
          r = '0;
          m = '0;
        end
        for (int k = 0; k < NI; k++) begin
          re_cnt[k] += int'(r[k]);
          im_cnt[k] += int'(m[k]);
        end
        taken++;
      end
      bus.iEn    = en;
      bus.iReal  = r;
      bus.iImg   = m;
      bus.iStart = 1'($urandom);
      bus.iReady = 1'($urandom);
      tick();
      cyc++;
      chk({tag, "_valid_timing"}, 64'(bus.oValid), 64'(taken == WIN));
      chk({tag, "_busy_timing"},  64'(bus.oBusy),  64'(taken != WIN));
    end
    bus.iEn    = 1'b0;
    bus.iStart = 1'b0;
    bus.iReady = 1'b0;
    if (taken < WIN) chk({tag, "_window_timeout"}, 64'd0, 64'd1);
    if (en_mode == 1) chk({tag, "_cycles"}, 64'(cyc), 64'(2 * WIN - 1));
    for (int k = 0; k < NI; k++) begin
      exp_re_v[k*CW +: CW] = CW'(re_cnt[k]);
      exp_im_v[k*CW +: CW] = CW'(im_cnt[k]);
    end
    chk({tag, "_real"}, 64'(bus.oReal), 64'(exp_re_v));
    chk({tag, "_img"},  64'(bus.oImg),  64'(exp_im_v));
  endtask

  task automatic handshake(input string tag);
    bus.iReady = 1'b1;
    tick();
    bus.iReady = 1'b0;
    chk_outputs({tag, "_hs"}, 1'b0, 1'b0, exp_re_v, exp_im_v);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.iEn    = 1'b0;
    bus.iClr   = 1'b0;
    bus.iStart = 1'b0;
    bus.iReal  = '0;
    bus.iImg   = '0;
    bus.iReady = 1'b0;
    rst_n      = 1'b0;
    #3;
    chk_outputs("por", 1'b0, 1'b0, '0, '0);
    #20;
    rst_n = 1'b1;
    tick();
    tick();
    chk_outputs("idle", 1'b0, 1'b0, '0, '0);

    // Spec pattern, continuous enable.
    run_window("w_cont", 0, 0);
    chk("w_cont_real_const", 64'(bus.oReal), 64'({5'd0, 5'd16}));
    chk("w_cont_img_const",  64'(bus.oImg),  64'({5'd8, 5'd8}));
    handshake("w_cont");

    // Same pattern with alternating enable; ignored cycles carry random lanes.
    run_window("w_gap", 0, 1);
    chk("w_gap_real_const", 64'(bus.oReal), 64'({5'd0, 5'd16}));
    chk("w_gap_img_const",  64'(bus.oImg),  64'({5'd8, 5'd8}));

    // Back-pressure in HOLD with iStart pulses.
    for (int i = 0; i < 5; i++) begin
      bus.iStart = (i % 2 == 0);
      bus.iEn    = 1'b1;
      bus.iReal  = NI'($urandom);
      tick();
      chk_outputs("hold_stall", 1'b1, 1'b0, exp_re_v, exp_im_v);
    end
    bus.iStart = 1'b0;
    bus.iEn    = 1'b0;
    handshake("hold");
    tick();
    chk_outputs("hold_after", 1'b0, 1'b0, exp_re_v, exp_im_v);

    // Clear on the 7th enabled sample.
    bus.iStart = 1'b1;
    tick();
    bus.iStart = 1'b0;
    bus.iEn    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.iReal = NI'($urandom);
      bus.iImg  = NI'($urandom);
      tick();
    end
    bus.iClr = 1'b1;
    tick();
    bus.iClr = 1'b0;
    exp_re_v = '0;
    exp_im_v = '0;
    chk_outputs("clr_mid", 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 20; i++) tick();
    chk_outputs("clr_idle", 1'b0, 1'b0, '0, '0);
    bus.iEn = 1'b0;
    run_window("w_zero", 1, 0);
    chk("w_zero_real_const", 64'(bus.oReal), 64'd0);
    handshake("w_zero");

    // Randomized windows.
    for (int w = 0; w < 4; w++) begin
      run_window("w_rand", 2, 2);
      for (int d = $urandom_range(0, 3); d > 0; d--) begin
        tick();
        chk_outputs("w_rand_wait", 1'b1, 1'b0, exp_re_v, exp_im_v);
      end
      handshake("w_rand");
    end

    // Clear and ready together in HOLD.
    run_window("w_clrhs", 2, 0);
    bus.iClr   = 1'b1;
    bus.iReady = 1'b1;
    tick();
    bus.iClr   = 1'b0;
    bus.iReady = 1'b0;
    chk_outputs("clr_hs", 1'b0, 1'b0, '0, '0);

    // Asynchronous reset mid-window, between clock edges.
    run_window("w_pre", 2, 0);
    handshake("w_pre");
    bus.iStart = 1'b1;
    tick();
    bus.iStart = 1'b0;
    bus.iEn    = 1'b1;
    bus.iReal  = '1;
    bus.iImg   = '1;
    for (int i = 0; i < 5; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_outputs("async_rst", 1'b0, 1'b0, '0, '0);
    bus.iEn = 1'b0;
    tick();
    chk_outputs("async_rst_hold", 1'b0, 1'b0, '0, '0);
    rst_n = 1'b1;
    tick();
    tick();
    chk_outputs("post_rst_idle", 1'b0, 1'b0, '0, '0);
    run_window("w_post", 2, 2);
    handshake("w_post");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
